// File: rtl/jam_cost_table_pkg.sv
// Shared types and sizes for the job-assignment cost table: FSM states, table geometry, result widths.
// Latency: n/a (declarations only). Backpressure: n/a.
// Optional lookup statistics are enabled by defining JAM_STATS_EN.
package jam_pkg;
    localparam int N_WORKERS  = 8;
    localparam int N_JOBS     = 8;
    localparam int COST_W     = 7;
    localparam int MINCOST_W  = 10;
    localparam int MATCH_W    = 4;
    localparam int TBL_ADDR_W = 6;
    localparam int REQCNT_W   = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2,
        DONE  = 2'd3
    } jam_state_t;
endpackage

// File: rtl/jam_cost_table_if.sv
// Load, lookup and engine-result signals of the cost table; master drives, slave is the table.
// Latency: n/a (wiring only). Backpressure: none, the table never stalls its requester.
// Statistics output ReqCount is meaningful only when JAM_STATS_EN is defined.
interface jam_cost_table_if #(
    parameter int COST_W = jam_pkg::COST_W
);
    import jam_pkg::*;

    logic                  LoadEn;
    logic [COST_W-1:0]     LoadData;
    logic [2:0]            W;
    logic [2:0]            J;
    logic                  Valid;
    logic [MINCOST_W-1:0]  MinCost;
    logic [MATCH_W-1:0]    MatchCount;
    logic [COST_W-1:0]     Cost;
    logic                  Ready;
    logic                  Done;
    logic [MINCOST_W-1:0]  ResultCost;
    logic [MATCH_W-1:0]    ResultCount;
    logic [REQCNT_W-1:0]   ReqCount;

    modport master (
        output LoadEn, LoadData, W, J, Valid, MinCost, MatchCount,
        input  Cost, Ready, Done, ResultCost, ResultCount, ReqCount
    );

    modport slave (
        input  LoadEn, LoadData, W, J, Valid, MinCost, MatchCount,
        output Cost, Ready, Done, ResultCost, ResultCount, ReqCount
    );
endinterface

// File: rtl/jam_cost_mem.sv
// 64-entry cost storage, one synchronous write port and one asynchronous read port; contents never reset.
// Latency: write visible after the write edge, read is combinational. Backpressure: none.
// Unaffected by JAM_STATS_EN.
module jam_cost_mem #(
    parameter int DATA_W = 7,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/jam_cost_table.sv
// Cost table for the job-assignment engine: 64-beat load, zero-latency {W,J} lookups, sticky capture of the engine result.
// Latency: Cost is combinational from W/J while serving; Ready the cycle after beat 64. Backpressure: none, load beats are qualified by LoadEn only.
// Defining JAM_STATS_EN adds a saturating count of serving cycles on ReqCount; otherwise ReqCount is tied to 0.
module jam_cost_table
    import jam_pkg::*;
#(
    parameter int COST_W = jam_pkg::COST_W
) (
    input  logic             CLK,
    input  logic             RST,
    jam_cost_table_if.slave  bus
);
    localparam int DEPTH = N_WORKERS * N_JOBS;

    jam_state_t              state, state_nxt;
    logic [TBL_ADDR_W-1:0]   load_addr, load_addr_nxt;
    logic [TBL_ADDR_W-1:0]   mem_waddr;
    logic                    mem_we;
    logic                    capture;
    logic [COST_W-1:0]       mem_rdata;
    logic [MINCOST_W-1:0]    result_cost;
    logic [MATCH_W-1:0]      result_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            load_addr <= '0;
        end else begin
            state     <= state_nxt;
            load_addr <= load_addr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        load_addr_nxt = load_addr;
        mem_we        = 1'b0;
        capture       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.LoadEn) begin
                    mem_we        = 1'b1;
                    load_addr_nxt = TBL_ADDR_W'(1);
                    state_nxt     = LOAD;
                end
            end
            LOAD: begin
                // the 6-bit address wraps to 0 on the entry-63 write
                if (bus.LoadEn) begin
                    mem_we        = 1'b1;
                    load_addr_nxt = load_addr + TBL_ADDR_W'(1);
                    if (load_addr == TBL_ADDR_W'(DEPTH - 1)) begin
                        state_nxt = SERVE;
                    end
                end
            end
            SERVE: begin
                if (bus.Valid) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_waddr = (state == IDLE) ? '0 : load_addr;

    jam_cost_mem #(
        .DATA_W (COST_W),
        .ADDR_W (TBL_ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .CLK   (CLK),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (bus.LoadData),
        .raddr ({bus.W, bus.J}),
        .rdata (mem_rdata)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            result_cost  <= '0;
            result_count <= '0;
        end else if (capture) begin
            result_cost  <= bus.MinCost;
            result_count <= bus.MatchCount;
        end
    end

`ifdef JAM_STATS_EN
    logic [REQCNT_W-1:0] req_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_cnt <= '0;
        end else if (state == SERVE && req_cnt != {REQCNT_W{1'b1}}) begin
            req_cnt <= req_cnt + REQCNT_W'(1);
        end
    end

    assign bus.ReqCount = req_cnt;
`else
    assign bus.ReqCount = '0;
`endif

    assign bus.Cost        = (state == SERVE) ? mem_rdata : '0;
    assign bus.Ready       = (state == SERVE);
    assign bus.Done        = (state == DONE);
    assign bus.ResultCost  = result_cost;
    assign bus.ResultCount = result_count;
endmodule

// File: tb/tb_jam_cost_table.sv
// Scoreboard bench for jam_cost_table: stimulus pushes expected lookups/results, a negedge monitor pops and compares.
// Honours JAM_STATS_EN for the expected ReqCount.
module tb_jam_cost_table;
    import jam_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    jam_cost_table_if bus ();

    jam_cost_table dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        int cost;
        int cnt;
    } res_t;

    int        n_chk  = 0;
    int        n_fail = 0;
    logic [6:0] model [64];
    logic [5:0] load_idx;
    int        cost_q [$];
    res_t      res_q  [$];
    bit        lk_vld = 1'b0;

    // monitor-owned state
    res_t      held;
    bit        have_res;
    int        serve_cnt;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_req(input int cycles);
`ifdef JAM_STATS_EN
        return (cycles > 32'h7FFFF) ? 32'h7FFFF : cycles;
`else
        return 0 * cycles;
`endif
    endfunction

    // monitor: compares whatever the DUT presents against the queued expectations
    always @(negedge CLK) begin
        if (RST) begin
            serve_cnt = 0;
            have_res  = 1'b0;
        end else begin
            if (lk_vld) begin
                if (cost_q.size() == 0) chk("lookup_queue_empty", 1, 0);
                else                    chk("lookup_cost", bus.Cost, cost_q.pop_front());
            end
            if (bus.Ready) begin
                chk("reqcount_serve", bus.ReqCount, exp_req(serve_cnt));
                serve_cnt++;
            end
            if (bus.Done) begin
                if (!have_res) begin
                    if (res_q.size() == 0) chk("unexpected_done", 1, 0);
                    else begin
                        held     = res_q.pop_front();
                        have_res = 1'b1;
                    end
                end
                if (have_res) begin
                    chk("result_cost",  bus.ResultCost,  held.cost);
                    chk("result_count", bus.ResultCount, held.cnt);
                    chk("ready_in_done", bus.Ready, 0);
                    chk("cost_in_done",  bus.Cost,  0);
                    chk("reqcount_hold", bus.ReqCount, exp_req(serve_cnt));
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.LoadEn = 1'b0; bus.Valid = 1'b0; lk_vld = 1'b0;
    endtask

    task automatic check_reset_state();
        chk("rst_ready", bus.Ready, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_cost", bus.Cost, 0);
        chk("rst_result_cost", bus.ResultCost, 0);
        chk("rst_result_count", bus.ResultCount, 0);
        chk("rst_reqcount", bus.ReqCount, 0);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1; idle_inputs(); load_idx = '0;
        @(negedge CLK);
        check_reset_state();
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic load_beat(input logic [6:0] d);
        @(posedge CLK); #1;
        idle_inputs();
        bus.LoadEn = 1'b1; bus.LoadData = d;
        bus.W = 3'($urandom_range(0, 7)); bus.J = 3'($urandom_range(0, 7));
        model[load_idx] = d;
        load_idx = load_idx + 6'd1;
        @(negedge CLK);
        chk("ready_during_load", bus.Ready, 0);
        chk("cost_during_load", bus.Cost, 0);
    endtask

    task automatic gap(input bit exp_ready);
        @(posedge CLK); #1;
        idle_inputs();
        bus.W = 3'($urandom_range(0, 7)); bus.J = 3'($urandom_range(0, 7));
        @(negedge CLK);
        chk(exp_ready ? "ready_after_beat64" : "ready_in_gap", bus.Ready, exp_ready);
        if (!exp_ready) chk("cost_in_gap", bus.Cost, 0);
    endtask

    task automatic lookup(input logic [2:0] w, input logic [2:0] j, input bit load_too);
        @(posedge CLK); #1;
        idle_inputs();
        bus.W = w; bus.J = j;
        if (load_too) begin
            bus.LoadEn = 1'b1; bus.LoadData = 7'd127;
        end
        cost_q.push_back(int'(model[{w, j}]));
        lk_vld = 1'b1;
    endtask

    task automatic engine_valid(input int mc, input int cnt, input bit expect_capture);
        @(posedge CLK); #1;
        idle_inputs();
        bus.Valid = 1'b1; bus.MinCost = 10'(mc); bus.MatchCount = 4'(cnt);
        if (expect_capture) res_q.push_back('{mc, cnt});
        @(posedge CLK); #1;
        bus.Valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gap_at [64];
        RST = 1'b1;
        idle_inputs();
        bus.LoadData = '0; bus.W = '0; bus.J = '0; bus.MinCost = '0; bus.MatchCount = '0;
        load_idx = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_reset_state();
        @(posedge CLK); #1;
        RST = 1'b0;

        // pattern load: entry {W,J} holds (W*8+J)%128
        for (int i = 0; i < 64; i++) load_beat(7'(i % 128));
        gap(1'b1);
        lookup(3'd3, 3'd5, 1'b0);
        @(negedge CLK);
        chk("cost_w3_j5", bus.Cost, 29);
        lookup(3'd0, 3'd0, 1'b1);
        lookup(3'd0, 3'd0, 1'b0);
        for (int i = 0; i < 995; i++)
            lookup(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
        engine_valid(312, 2, 1'b1);
        @(negedge CLK);
        chk("done_set", bus.Done, 1);
`ifdef JAM_STATS_EN
        chk("reqcount_1000", bus.ReqCount, 1000);
`else
        chk("reqcount_zero", bus.ReqCount, 0);
`endif
        repeat (3) gap(1'b0);
        engine_valid(100, 5, 1'b0);
        repeat (3) gap(1'b0);
        chk("done_sticky", bus.Done, 1);
        chk("result_cost_sticky", bus.ResultCost, 312);
        chk("result_count_sticky", bus.ResultCount, 2);

        // partial load, reset, then a full gapped reload of fresh data
        do_reset();
        for (int i = 0; i < 30; i++) load_beat(7'($urandom));
        do_reset();
        for (int g = 0; g < 10; g++) gap_at[$urandom_range(1, 63)]++;
        for (int i = 0; i < 64; i++) begin
            repeat (gap_at[i]) gap(1'b0);
            load_beat(7'($urandom));
        end
        gap(1'b1);
        for (int i = 0; i < 64; i++) lookup(3'(i / 8), 3'(i % 8), 1'b0);
        repeat (2) gap(1'b1);
        chk("lookup_queue_drained", cost_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
